// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle between the instruction producer, the immediate generator
// and the execute-stage consumer.
//
// Valid/ready rule for both sides: a transfer happens on the rising edge
// where valid and ready are both high; the source holds its payload stable
// while valid is high and ready is low, and ready never depends on valid.
interface imm_gen_pipe_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic            less;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] imm;
  logic [2:0]      fmt;
  logic            illegal;

  // Producer/consumer side (the environment around the block)
  modport master (
    output in_valid, instr, less, out_ready,
    input  in_ready, out_valid, imm, fmt, illegal
  );

  // Immediate generator side
  modport slave (
    input  in_valid, instr, less, out_ready,
    output in_ready, out_valid, imm, fmt, illegal
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Immediate generator: decodes the base-ISA immediate of a 32-bit instruction,
// sign-extends it to XLEN and queues {imm, fmt, illegal} in a DEPTH-entry FIFO
// so decode is decoupled from execute. Also counts accepted illegal formats.
module imm_gen_pipe #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset,
  imm_gen_pipe_if.slave       bus,
  input  logic                clear_cnt,
  output logic [15:0]         illegal_cnt
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_IMMW  = 7'b0011011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  logic [31:0]     ext32;
  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic            dec_illegal;
  logic [31:0]     imm_i;

  logic [XLEN-1:0] mem_imm [DEPTH];
  logic [2:0]      mem_fmt [DEPTH];
  logic            mem_ill [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            push;
  logic            pop;

  assign imm_i = {{20{bus.instr[31]}}, bus.instr[31:20]};

  // Decode the immediate into a sign-extended 32-bit value, then widen it.
  // R-type slt result has bit 31 clear, so the widening leaves it zero-extended.
  always_comb begin
    ext32       = '0;
    dec_fmt     = FMT_ILL;
    dec_illegal = 1'b1;
    case (bus.instr[6:0])
      OP_R: begin
        ext32 = {31'b0, bus.less}; dec_fmt = FMT_R; dec_illegal = 1'b0;
      end
      OP_IMM, OP_LOAD: begin
        ext32 = imm_i; dec_fmt = FMT_I; dec_illegal = 1'b0;
      end
      OP_JALR: begin
        if (bus.instr[14:12] == 3'b000) begin
          ext32 = imm_i; dec_fmt = FMT_I; dec_illegal = 1'b0;
        end
      end
      OP_IMMW: begin
        if (XLEN == 64) begin
          ext32 = imm_i; dec_fmt = FMT_I; dec_illegal = 1'b0;
        end
      end
      OP_STORE: begin
        ext32 = {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
        dec_fmt = FMT_S; dec_illegal = 1'b0;
      end
      OP_BR: begin
        ext32 = {{19{bus.instr[31]}}, bus.instr[31], bus.instr[7],
                 bus.instr[30:25], bus.instr[11:8], 1'b0};
        dec_fmt = FMT_B; dec_illegal = 1'b0;
      end
      OP_LUI, OP_AUIPC: begin
        ext32 = {bus.instr[31:12], 12'b0}; dec_fmt = FMT_U; dec_illegal = 1'b0;
      end
      OP_JAL: begin
        ext32 = {{11{bus.instr[31]}}, bus.instr[31], bus.instr[19:12],
                 bus.instr[20], bus.instr[30:21], 1'b0};
        dec_fmt = FMT_J; dec_illegal = 1'b0;
      end
      default: begin
        ext32 = '0; dec_fmt = FMT_ILL; dec_illegal = 1'b1;
      end
    endcase
    dec_imm = XLEN'($signed(ext32));
  end

  // in_ready looks only at registered occupancy, so a full FIFO stalls input
  // for a cycle even when the consumer pops it in that same cycle.
  assign bus.in_ready  = (count < DEPTH_C);
  assign bus.out_valid = (count != '0);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  // Head outputs come from storage and read as zero while the FIFO is empty.
  assign bus.imm     = bus.out_valid ? mem_imm[rd_ptr] : '0;
  assign bus.fmt     = bus.out_valid ? mem_fmt[rd_ptr] : 3'd0;
  assign bus.illegal = bus.out_valid ? mem_ill[rd_ptr] : 1'b0;

  // Write the decoded entry into the slot at the write pointer.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_imm[wr_ptr] <= dec_imm;
      mem_fmt[wr_ptr] <= dec_fmt;
      mem_ill[wr_ptr] <= dec_illegal;
    end
  end

  // Pointers wrap naturally at DEPTH (a power of two); occupancy tracks push/pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Saturating count of accepted illegal instructions; clear wins over increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_cnt <= '0;
    end else if (clear_cnt) begin
      illegal_cnt <= '0;
    end else if (push && dec_illegal && (illegal_cnt != 16'hFFFF)) begin
      illegal_cnt <= illegal_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: an XLEN=64 instance fed through a scoreboard and an
// XLEN=32 instance for width-dependent cases.
module tb_imm_gen_pipe;
  logic        clk = 1'b0;
  logic        reset;
  logic        clear_cnt;
  logic [15:0] illegal_cnt;
  logic        clear_cnt32;
  logic [15:0] illegal_cnt32;

  int checks   = 0;
  int failures = 0;

  logic [67:0] exp_q[$];

  imm_gen_pipe_if #(.XLEN(64)) bus ();
  imm_gen_pipe_if #(.XLEN(32)) bus32 ();

  imm_gen_pipe #(.XLEN(64), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .clear_cnt(clear_cnt), .illegal_cnt(illegal_cnt)
  );

  imm_gen_pipe #(.XLEN(32), .DEPTH(2)) dut32 (
    .clk(clk), .reset(reset), .bus(bus32),
    .clear_cnt(clear_cnt32), .illegal_cnt(illegal_cnt32)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [67:0] model(input logic [31:0] i, input logic l);
    logic [63:0] v;
    logic [2:0]  f;
    logic        il;
    v = '0; f = 3'd7; il = 1'b1;
    case (i[6:0])
      7'h33: begin v = {63'b0, l}; f = 3'd0; il = 1'b0; end
      7'h13, 7'h03, 7'h1B: begin v = {{52{i[31]}}, i[31:20]}; f = 3'd1; il = 1'b0; end
      7'h67: if (i[14:12] == 3'b000) begin v = {{52{i[31]}}, i[31:20]}; f = 3'd1; il = 1'b0; end
      7'h23: begin v = {{52{i[31]}}, i[31:25], i[11:7]}; f = 3'd2; il = 1'b0; end
      7'h63: begin v = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0}; f = 3'd3; il = 1'b0; end
      7'h37, 7'h17: begin v = {{32{i[31]}}, i[31:12], 12'b0}; f = 3'd4; il = 1'b0; end
      7'h6F: begin v = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0}; f = 3'd5; il = 1'b0; end
      default: begin v = '0; f = 3'd7; il = 1'b1; end
    endcase
    return {v, f, il};
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [67:0] e;
    if (!reset && bus.out_valid && bus.out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected got imm=%h fmt=%0d ill=%b, queue empty", bus.imm, bus.fmt, bus.illegal);
      end else begin
        e = exp_q.pop_front();
        if ({bus.imm, bus.fmt, bus.illegal} !== e) begin
          failures++;
          $display("FAIL sb_entry got imm=%h fmt=%0d ill=%b expected imm=%h fmt=%0d ill=%b",
                   bus.imm, bus.fmt, bus.illegal, e[67:4], e[3:1], e[0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic drive(input logic [31:0] ins, input logic l);
    int budget;
    bit done;
    budget = 0; done = 1'b0;
    bus.instr = ins; bus.less = l; bus.in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back(model(ins, l));
        done = 1'b1;
      end
      @(posedge clk); #1;
      budget++;
      if (!done && budget > 200) begin
        checks++; failures++;
        $display("FAIL drive_timeout instr=%h in_ready=%b, expected accept", ins, bus.in_ready);
        done = 1'b1;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    bus.out_ready = 1'b1;
    while (exp_q.size() != 0 && budget < 200) begin
      @(posedge clk); #1;
      budget++;
    end
    @(posedge clk); #1;
    checks++;
    if (exp_q.size() != 0 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL drain pending=%0d out_valid=%b, expected 0 and 0", exp_q.size(), bus.out_valid);
    end
    checks++;
    if ({bus.imm, bus.fmt, bus.illegal} !== 68'd0) begin
      failures++;
      $display("FAIL empty_outputs imm=%h fmt=%0d ill=%b, expected all 0", bus.imm, bus.fmt, bus.illegal);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; clear_cnt = 1'b0; clear_cnt32 = 1'b0;
    bus.in_valid = 1'b0; bus.instr = '0; bus.less = 1'b0; bus.out_ready = 1'b0;
    bus32.in_valid = 1'b0; bus32.instr = '0; bus32.less = 1'b0; bus32.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.out_valid, bus.imm, bus.fmt, bus.illegal, illegal_cnt} !== 85'd0) begin
      failures++;
      $display("FAIL reset_outputs out_valid=%b imm=%h fmt=%0d ill=%b cnt=%h, expected all 0",
               bus.out_valid, bus.imm, bus.fmt, bus.illegal, illegal_cnt);
    end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release in_ready=%b out_valid=%b, expected 1 0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_sign_ext();
    bus.out_ready = 1'b1;
    drive(32'hFFF00093, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.imm !== 64'hFFFF_FFFF_FFFF_FFFF || bus.fmt !== 3'd1) begin
      failures++;
      $display("FAIL addi_neg out_valid=%b imm=%h fmt=%0d, expected 1 ffffffffffffffff 1", bus.out_valid, bus.imm, bus.fmt);
    end
    drive(32'hFE000EE3, 1'b0);
    checks++;
    if (bus.imm !== 64'hFFFF_FFFF_FFFF_FFFC || bus.fmt !== 3'd3) begin
      failures++;
      $display("FAIL beq_neg imm=%h fmt=%0d, expected fffffffffffffffc 3", bus.imm, bus.fmt);
    end
    drain();
  endtask

  task automatic test_u_j();
    bus.out_ready = 1'b1;
    drive(32'h0010006F, 1'b0);
    checks++;
    if (bus.imm !== 64'h800 || bus.fmt !== 3'd5) begin
      failures++;
      $display("FAIL jal_2048 imm=%h fmt=%0d, expected 800 5", bus.imm, bus.fmt);
    end
    drive(32'h800000B7, 1'b0);
    checks++;
    if (bus.imm !== 64'hFFFF_FFFF_8000_0000 || bus.fmt !== 3'd4) begin
      failures++;
      $display("FAIL lui_64 imm=%h fmt=%0d, expected ffffffff80000000 4", bus.imm, bus.fmt);
    end
    drain();
  endtask

  task automatic test_r_slt();
    bus.out_ready = 1'b1;
    drive(32'h0020A033, 1'b1);
    checks++;
    if (bus.imm !== 64'd1 || bus.fmt !== 3'd0 || bus.illegal !== 1'b0) begin
      failures++;
      $display("FAIL slt_less1 imm=%h fmt=%0d ill=%b, expected 1 0 0", bus.imm, bus.fmt, bus.illegal);
    end
    drive(32'h0020A033, 1'b0);
    checks++;
    if (bus.imm !== 64'd0 || bus.fmt !== 3'd0) begin
      failures++;
      $display("FAIL slt_less0 imm=%h fmt=%0d, expected 0 0", bus.imm, bus.fmt);
    end
    drive(32'h0010809B, 1'b0);
    checks++;
    if (bus.imm !== 64'd1 || bus.fmt !== 3'd1 || bus.illegal !== 1'b0) begin
      failures++;
      $display("FAIL addiw_64 imm=%h fmt=%0d ill=%b, expected 1 1 0", bus.imm, bus.fmt, bus.illegal);
    end
    drive(32'h00001067, 1'b0);
    checks++;
    if (bus.fmt !== 3'd7 || bus.illegal !== 1'b1) begin
      failures++;
      $display("FAIL jalr_f3 fmt=%0d ill=%b, expected 7 1", bus.fmt, bus.illegal);
    end
    drain();
  endtask

  task automatic test_xlen32();
    bus32.out_ready = 1'b1;
    bus32.instr = 32'h800000B7; bus32.in_valid = 1'b1;
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
    checks++;
    if (bus32.out_valid !== 1'b1 || bus32.imm !== 32'h8000_0000 || bus32.fmt !== 3'd4) begin
      failures++;
      $display("FAIL lui_32 out_valid=%b imm=%h fmt=%0d, expected 1 80000000 4", bus32.out_valid, bus32.imm, bus32.fmt);
    end
    bus32.instr = 32'h0010809B; bus32.in_valid = 1'b1;
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
    checks++;
    if (bus32.imm !== 32'd0 || bus32.fmt !== 3'd7 || bus32.illegal !== 1'b1 || illegal_cnt32 !== 16'd1) begin
      failures++;
      $display("FAIL addiw_32 imm=%h fmt=%0d ill=%b cnt=%0d, expected 0 7 1 1",
               bus32.imm, bus32.fmt, bus32.illegal, illegal_cnt32);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    drive(32'h00100093, 1'b0);
    drive(32'h00200113, 1'b0);
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL full_in_ready in_ready=%b out_valid=%b, expected 0 1", bus.in_ready, bus.out_valid);
    end
    bus.out_ready = 1'b1;
    bus.instr = 32'h00300193; bus.in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_stall in_ready=%b, expected 0 while popping a full FIFO", bus.in_ready);
    end
    @(posedge clk); #1;
    drive(32'h00300193, 1'b0);
    drain();
  endtask

  task automatic test_back_to_back();
    logic [6:0]  ops [12];
    logic [31:0] r;
    bit          stim_done;
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F, 7'h00};
    stim_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          r = $urandom();
          drive({r[31:7], ops[$urandom_range(0, 11)]}, 1'($urandom_range(0, 1)));
        end
        stim_done = 1'b1;
      end
      begin
        while (!stim_done) begin
          @(posedge clk); #1;
          bus.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();
  endtask

  task automatic test_illegal_cnt();
    bus.out_ready = 1'b1;
    clear_cnt = 1'b1;
    @(posedge clk); #1;
    clear_cnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(32'h0000007F, 1'b0);
      checks++;
      if (bus.illegal !== 1'b1 || bus.fmt !== 3'd7 || bus.imm !== 64'd0) begin
        failures++;
        $display("FAIL illegal_head ill=%b fmt=%0d imm=%h, expected 1 7 0", bus.illegal, bus.fmt, bus.imm);
      end
    end
    checks++;
    if (illegal_cnt !== 16'd3) begin
      failures++;
      $display("FAIL illegal_cnt3 cnt=%0d, expected 3", illegal_cnt);
    end
    clear_cnt = 1'b1;
    drive(32'h0000007F, 1'b0);
    clear_cnt = 1'b0;
    checks++;
    if (illegal_cnt !== 16'd0) begin
      failures++;
      $display("FAIL clear_wins cnt=%0d, expected 0", illegal_cnt);
    end
    for (int i = 0; i < 65535; i++) drive(32'h0000007F, 1'b0);
    checks++;
    if (illegal_cnt !== 16'hFFFF) begin
      failures++;
      $display("FAIL cnt_full cnt=%h, expected ffff", illegal_cnt);
    end
    drive(32'h0000007F, 1'b0);
    checks++;
    if (illegal_cnt !== 16'hFFFF) begin
      failures++;
      $display("FAIL cnt_saturate cnt=%h, expected ffff", illegal_cnt);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    drive(32'h0000007F, 1'b0);
    drive(32'h0000007F, 1'b0);
    #2 reset = 1'b1;
    #1;
    exp_q.delete();
    checks++;
    if (bus.out_valid !== 1'b0 || illegal_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_async out_valid=%b cnt=%0d, expected 0 0", bus.out_valid, illegal_cnt);
    end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_release in_ready=%b out_valid=%b, expected 1 0", bus.in_ready, bus.out_valid);
    end
    bus.out_ready = 1'b1;
    drive(32'h00000517, 1'b0);
    drain();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_sign_ext();
    test_u_j();
    test_r_slt();
    test_xlen32();
    test_backpressure();
    test_back_to_back();
    test_illegal_cnt();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
